score_ram_arbiter: RTL and testbench

//  Sequences and shares the single-port score RAM between the score writer (per-answer

---
 rtl/score_pkg.sv | 21 ++
 rtl/score_rr_arb2.sv | 21 ++
 rtl/score_ram_arbiter.sv | 140 ++++++++++++++
 tb/tb_score_ram_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared definitions for the score RAM arbiter slice.
//   DW_DEF / AW_DEF : default score word width and RAM address width
//   state_e         : arbiter FSM states
//   GNT_WR / GNT_RD : grant ids; also the bit index of each requester in req/gnt vectors
package score_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        RD_ADDR = 3'd2,
        RD_DATA = 3'd3,
        CLEAR   = 3'd4
    } state_e;

    localparam logic GNT_WR = 1'b0;
    localparam logic GNT_RD = 1'b1;

endpackage

// File: rtl/score_rr_arb2.sv
// Two-way round-robin picker.
//   req_i      : [GNT_WR] writer pending, [GNT_RD] reader pending
//   last_gnt_i : id of the requester served last (GNT_WR / GNT_RD)
//   gnt_o      : one-hot grant, same bit order as req_i; zero when nothing is pending
module score_rr_arb2
    import score_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_gnt_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        // Contention: hand the slot to whoever was not served last.
        if (req_i == 2'b11) begin
            gnt_o = (last_gnt_i == GNT_RD) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/score_ram_arbiter.sv
// Sole driver of the single-port score RAM. Shares it between the score writer
// and the display reader (round-robin) and runs a bulk-clear sweep on request.
//   Clk, Reset          : clock, synchronous active-low reset
//   WrReq/WrAddr/WrData : writer request (level), acked by a 1-cycle WrAck pulse
//   RdReq/RdAddr        : reader request (level), answered by RdValid pulse + RdData
//   ClrReq              : bulk clear; ClrBusy during the sweep, ClrDone pulse after it
//   RamAddr/RamWe/RamDin: RAM control; RamDout is the synchronous-read RAM output
// Every output comes straight from a flop, so there is no input-to-output path.
module score_ram_arbiter
    import score_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          WrReq,
    input  logic [AW-1:0] WrAddr,
    input  logic [DW-1:0] WrData,
    output logic          WrAck,
    input  logic          RdReq,
    input  logic [AW-1:0] RdAddr,
    output logic          RdValid,
    output logic [DW-1:0] RdData,
    input  logic          ClrReq,
    output logic          ClrBusy,
    output logic          ClrDone,
    output logic [AW-1:0] RamAddr,
    output logic          RamWe,
    output logic [DW-1:0] RamDin,
    input  logic [DW-1:0] RamDout
);

    state_e        state_q;
    logic [AW-1:0] clr_cnt_q;
    logic [AW-1:0] clr_cnt_d;
    logic          last_gnt_q;
    logic [1:0]    gnt;

    logic          wr_ack_q;
    logic          rd_valid_q;
    logic [DW-1:0] rd_data_q;
    logic          clr_busy_q;
    logic          clr_done_q;
    logic [AW-1:0] ram_addr_q;
    logic          ram_we_q;
    logic [DW-1:0] ram_din_q;

    score_rr_arb2 u_rr (
        .req_i      ({RdReq, WrReq}),
        .last_gnt_i (last_gnt_q),
        .gnt_o      (gnt)
    );

    assign clr_cnt_d = clr_cnt_q + 1'b1;

    // The RAM address/data registers double as the grant-time latches: they are
    // loaded only on the grant edge, so later input changes cannot reach the RAM.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= IDLE;
            clr_cnt_q  <= '0;
            last_gnt_q <= GNT_RD;
            wr_ack_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
            ram_addr_q <= '0;
            ram_we_q   <= 1'b0;
            ram_din_q  <= '0;
        end else begin
            // Status pulses last exactly one cycle.
            wr_ack_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            clr_done_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (ClrReq) begin
                        state_q    <= CLEAR;
                        clr_cnt_q  <= '0;
                        ram_addr_q <= '0;
                        ram_din_q  <= '0;
                        ram_we_q   <= 1'b1;
                        clr_busy_q <= 1'b1;
                    end else if (gnt[GNT_WR]) begin
                        state_q    <= WRITE;
                        last_gnt_q <= GNT_WR;
                        ram_addr_q <= WrAddr;
                        ram_din_q  <= WrData;
                        ram_we_q   <= 1'b1;
                        wr_ack_q   <= 1'b1;
                    end else if (gnt[GNT_RD]) begin
                        state_q    <= RD_ADDR;
                        last_gnt_q <= GNT_RD;
                        ram_addr_q <= RdAddr;
                    end
                end
                WRITE: begin
                    ram_we_q <= 1'b0;
                    state_q  <= IDLE;
                end
                RD_ADDR: begin
                    state_q <= RD_DATA;
                end
                RD_DATA: begin
                    rd_data_q  <= RamDout;
                    rd_valid_q <= 1'b1;
                    state_q    <= IDLE;
                end
                CLEAR: begin
                    if (clr_cnt_q == {AW{1'b1}}) begin
                        state_q    <= IDLE;
                        clr_cnt_q  <= '0;
                        ram_we_q   <= 1'b0;
                        clr_busy_q <= 1'b0;
                        clr_done_q <= 1'b1;
                    end else begin
                        clr_cnt_q  <= clr_cnt_d;
                        ram_addr_q <= clr_cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign WrAck   = wr_ack_q;
    assign RdValid = rd_valid_q;
    assign RdData  = rd_data_q;
    assign ClrBusy = clr_busy_q;
    assign ClrDone = clr_done_q;
    assign RamAddr = ram_addr_q;
    assign RamWe   = ram_we_q;
    assign RamDin  = ram_din_q;

endmodule

// File: tb/tb_score_ram_arbiter.sv
// Self-checking bench for score_ram_arbiter with a behavioural single-port RAM.
// Expected read data is queued when a read is issued and compared when RdValid appears.
module tb_score_ram_arbiter;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 1 << AW;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          WrReq;
    logic [AW-1:0] WrAddr;
    logic [DW-1:0] WrData;
    logic          WrAck;
    logic          RdReq;
    logic [AW-1:0] RdAddr;
    logic          RdValid;
    logic [DW-1:0] RdData;
    logic          ClrReq;
    logic          ClrBusy;
    logic          ClrDone;
    logic [AW-1:0] RamAddr;
    logic          RamWe;
    logic [DW-1:0] RamDin;
    logic [DW-1:0] RamDout;

    logic [DW-1:0] ram_mem [DEPTH];
    logic [DW-1:0] exp_mem [DEPTH];
    logic [DW-1:0] exp_q [$];

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    score_ram_arbiter #(.DW(DW), .AW(AW)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .WrReq   (WrReq),
        .WrAddr  (WrAddr),
        .WrData  (WrData),
        .WrAck   (WrAck),
        .RdReq   (RdReq),
        .RdAddr  (RdAddr),
        .RdValid (RdValid),
        .RdData  (RdData),
        .ClrReq  (ClrReq),
        .ClrBusy (ClrBusy),
        .ClrDone (ClrDone),
        .RamAddr (RamAddr),
        .RamWe   (RamWe),
        .RamDin  (RamDin),
        .RamDout (RamDout)
    );

    // Single-port RAM, synchronous read.
    always @(posedge Clk) begin
        if (RamWe) ram_mem[RamAddr] <= RamDin;
        RamDout <= ram_mem[RamAddr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Scoreboard consumer.
    always @(negedge Clk) begin
        if (Reset && RdValid) begin
            if (exp_q.size() == 0) chk("rd_unexpected", 1, 0);
            else chk("rd_data", {24'd0, RdData}, {24'd0, exp_q.pop_front()});
        end
    end

    function automatic logic [31:0] all_outs();
        return {7'd0, WrAck, RdValid, RdData, ClrBusy, ClrDone, RamAddr, RamWe, RamDin};
    endfunction

    task automatic apply_reset();
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        chk("rst_outs", all_outs(), 0);
        Reset = 1'b1;
        @(negedge Clk);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        WrAddr = a; WrData = d; WrReq = 1'b1;
        do begin @(negedge Clk); n++; end while (!WrAck && n < 20);
        WrReq = 1'b0;
        chk("wr_ack_lat", n, 1);
        exp_mem[a] = d;
        @(negedge Clk);
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        int n = 0;
        exp_q.push_back(exp_mem[a]);
        RdAddr = a; RdReq = 1'b1;
        do begin @(negedge Clk); n++; end while (!RdValid && n < 20);
        RdReq = 1'b0;
        chk("rd_lat", n, 3);
        @(negedge Clk);
    endtask

    task automatic fill_ram();
        for (int a = 0; a < DEPTH; a++) do_write(AW'(a), DW'(a + 1));
    endtask

    initial begin
        int n, busy, done, ev_n, done_cyc, ack_cyc;
        int ev [4];
        for (int i = 0; i < DEPTH; i++) begin ram_mem[i] = '0; exp_mem[i] = '0; end
        Reset = 1'b0; WrReq = 1'b0; WrAddr = '0; WrData = '0;
        RdReq = 1'b0; RdAddr = '0; ClrReq = 1'b0;
        @(negedge Clk);
        apply_reset();

        // 1. write then read
        do_write(4'd3, 8'h05);
        do_read(4'd3);

        // 2. simultaneous requests after reset: W first, then alternation
        apply_reset();
        WrAddr = 4'd1; WrData = 8'h0A; RdAddr = 4'd1;
        exp_q.push_back(8'h0A); exp_q.push_back(8'h0A);
        WrReq = 1'b1; RdReq = 1'b1;
        ev_n = 0; n = 0;
        while (ev_n < 4 && n < 60) begin
            @(negedge Clk); n++;
            if (WrAck) begin ev[ev_n] = 0; ev_n++; end
            else if (RdValid) begin ev[ev_n] = 1; ev_n++; end
        end
        WrReq = 1'b0; RdReq = 1'b0;
        exp_mem[1] = 8'h0A;
        chk("rr_events", ev_n, 4);
        for (int i = 0; i < 4; i++) chk("rr_order", ev[i], i % 2);
        @(negedge Clk);

        // 3. fill then clear sweep
        fill_ram();
        ClrReq = 1'b1;
        busy = 0; done = 0; n = 0;
        while (done == 0 && n < 40) begin
            @(negedge Clk); n++;
            ClrReq = 1'b0;
            if (ClrBusy) begin
                chk("clr_drive", {RamWe, RamDin, 3'd0, RamAddr}, {1'b1, 8'h00, 3'd0, 4'(busy)});
                busy++;
            end
            if (ClrDone) done++;
        end
        chk("clr_busy_cycles", busy, 16);
        chk("clr_done_count", done, 1);
        @(negedge Clk);
        chk("clr_done_pulse", ClrDone, 0);
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
        do_read(4'd0);
        do_read(4'd7);
        do_read(4'd15);

        // 4. clear and write in the same cycle: clear first, write survives
        WrAddr = 4'd5; WrData = 8'h55; WrReq = 1'b1; ClrReq = 1'b1;
        done_cyc = 0; ack_cyc = 0; n = 0;
        while (ack_cyc == 0 && n < 40) begin
            @(negedge Clk); n++;
            ClrReq = 1'b0;
            if (ClrDone) done_cyc = n;
            if (WrAck) ack_cyc = n;
        end
        WrReq = 1'b0;
        chk("clrwr_done_cyc", done_cyc, 17);
        chk("clrwr_ack_cyc", ack_cyc, 18);
        exp_mem[5] = 8'h55;
        @(negedge Clk);
        do_read(4'd5);
        do_read(4'd4);

        // 5a. reset during RD_DATA
        RdAddr = 4'd5; RdReq = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0; RdReq = 1'b0;
        @(negedge Clk);
        chk("rst_rd_outs", all_outs(), 0);
        Reset = 1'b1;
        repeat (4) @(negedge Clk);

        // 5b. reset at clear counter 6
        fill_ram();
        ClrReq = 1'b1; n = 0;
        do begin @(negedge Clk); ClrReq = 1'b0; n++; end
        while (!(ClrBusy && RamAddr == 4'd6) && n < 40);
        chk("clr_reach6", n, 7);
        Reset = 1'b0;
        @(negedge Clk);
        chk("rst_clr_busy", ClrBusy, 0);
        chk("rst_clr_outs", all_outs(), 0);
        Reset = 1'b1;
        done = 0;
        repeat (20) begin @(negedge Clk); if (ClrDone) done++; end
        chk("rst_clr_nodone", done, 0);
        for (int i = 0; i <= 6; i++) exp_mem[i] = '0;
        do_read(4'd0);
        do_read(4'd7);
        do_read(4'd15);

        // 6. write data changes in the WRITE cycle: latched value stored
        WrAddr = 4'd9; WrData = 8'h11; WrReq = 1'b1;
        @(negedge Clk);
        chk("latch_ack", WrAck, 1);
        WrData = 8'h22; WrReq = 1'b0;
        @(negedge Clk);
        exp_mem[9] = 8'h11;
        do_read(4'd9);

        repeat (3) @(negedge Clk);
        chk("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
